// File: rtl/spi_pkg.sv
// Shared spi_top command encodings and sequencer state type.
// RDATA encodes as zero so an idle command bus reads as all zeros.
package spi_pkg;

    typedef enum logic [3:0] {
        RDATA    = 4'h0,
        RDATAC   = 4'h1,
        SDATAC   = 4'h2,
        SELFCAL  = 4'h3,
        SELFOCAL = 4'h4,
        SELFGCAL = 4'h5,
        SYNC     = 4'h6,
        WAKEUP   = 4'h7,
        RREG     = 4'h8,
        WREG     = 4'h9
    } transaction_t;

    typedef enum logic [2:0] {
        SEQ_IDLE      = 3'd0,
        SEQ_CAL_ISSUE = 3'd1,
        SEQ_CAL_WAIT  = 3'd2,
        SEQ_ARM       = 3'd3,
        SEQ_RD_ISSUE  = 3'd4,
        SEQ_RD_WAIT   = 3'd5
    } seq_state_t;

endpackage

// File: rtl/drdy_edge_sync.sv
// Synchronises the asynchronous DRDY_L pin and emits a one-cycle pulse on its falling edge.
// Pin-to-pulse latency is three clocks; a pin held low produces a single pulse.
module drdy_edge_sync (
    input  logic clk,
    input  logic reset_n,
    input  logic drdy_n,
    output logic fall
);

    logic meta_reg;
    logic sync_reg;
    logic sync_d_reg;
    logic fall_reg;

    // Flops clear low so a pin already low when reset releases cannot fake an edge.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            meta_reg   <= 1'b0;
            sync_reg   <= 1'b0;
            sync_d_reg <= 1'b0;
            fall_reg   <= 1'b0;
        end else begin
            meta_reg   <= drdy_n;
            sync_reg   <= meta_reg;
            sync_d_reg <= sync_reg;
            fall_reg   <= sync_d_reg & ~sync_reg;
        end
    end

    assign fall = fall_reg;

endmodule

// File: rtl/adc_acq_sequencer.sv
// Command sequencer for spi_top: optional SELFCAL, then one RDATA per DRDY falling edge
// until the target count or a stop request; flags DRDY overruns and hung transactions.
module adc_acq_sequencer
    import spi_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int TIMEOUT_CYC = 100_000_000,
    parameter bit DO_SELFCAL  = 1'b1
) (
    input  logic             clock_i,
    input  logic             reset_L_i,
    input  logic             start_i,
    input  logic             stop_i,
    input  logic [CNT_W-1:0] num_samples_i,
    input  logic             DRDY_L_i,
    output logic             transaction_start_o,
    output transaction_t     transaction_o,
    input  logic             transaction_done_i,
    output logic             busy_o,
    output logic [CNT_W-1:0] sample_count_o,
    output logic             overrun_o,
    output logic             timeout_o
);

    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

    seq_state_t       state_reg, state_next;
    logic [CNT_W-1:0] target_reg;
    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_inc;
    logic [TMO_W-1:0] tmo_cnt_reg;
    logic             overrun_reg;
    logic             timeout_reg;
    logic             stop_pend_reg;
    logic             drdy_fall;
    logic             in_issue;
    logic             in_wait;
    logic             tmo_expired;
    logic             hit_target;
    logic             accept_start;

    drdy_edge_sync u_drdy_edge_sync (
        .clk     (clock_i),
        .reset_n (reset_L_i),
        .drdy_n  (DRDY_L_i),
        .fall    (drdy_fall)
    );

    assign in_issue     = (state_reg == SEQ_CAL_ISSUE) || (state_reg == SEQ_RD_ISSUE);
    assign in_wait      = (state_reg == SEQ_CAL_WAIT)  || (state_reg == SEQ_RD_WAIT);
    assign tmo_expired  = (tmo_cnt_reg == TMO_LAST);
    assign count_inc    = (&count_reg) ? count_reg : count_reg + 1'b1;
    assign hit_target   = (target_reg != '0) && (count_inc == target_reg);
    assign accept_start = (state_reg == SEQ_IDLE) && start_i && !stop_i;

    always_ff @(posedge clock_i) begin
        if (!reset_L_i) begin
            state_reg <= SEQ_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            SEQ_IDLE: begin
                if (start_i && !stop_i) begin
                    state_next = DO_SELFCAL ? SEQ_CAL_ISSUE : SEQ_ARM;
                end
            end
            SEQ_CAL_ISSUE: state_next = SEQ_CAL_WAIT;
            SEQ_CAL_WAIT: begin
                if (transaction_done_i) begin
                    state_next = (stop_pend_reg || stop_i) ? SEQ_IDLE : SEQ_ARM;
                end else if (tmo_expired) begin
                    state_next = SEQ_IDLE;
                end
            end
            SEQ_ARM: begin
                if (stop_i) begin
                    state_next = SEQ_IDLE;
                end else if (drdy_fall) begin
                    state_next = SEQ_RD_ISSUE;
                end
            end
            SEQ_RD_ISSUE: state_next = SEQ_RD_WAIT;
            SEQ_RD_WAIT: begin
                if (transaction_done_i) begin
                    state_next = (stop_pend_reg || stop_i || hit_target) ? SEQ_IDLE : SEQ_ARM;
                end else if (tmo_expired) begin
                    state_next = SEQ_IDLE;
                end
            end
            default: state_next = SEQ_IDLE;
        endcase
    end

    always_comb begin
        transaction_start_o = 1'b0;
        transaction_o       = RDATA;
        busy_o              = (state_reg != SEQ_IDLE);
        case (state_reg)
            SEQ_CAL_ISSUE: begin
                transaction_start_o = 1'b1;
                transaction_o       = SELFCAL;
            end
            SEQ_CAL_WAIT: transaction_o = SELFCAL;
            SEQ_RD_ISSUE: transaction_start_o = 1'b1;
            default: ;
        endcase
    end

    // A stop arriving while a frame is launched or in flight is deferred until its done.
    always_ff @(posedge clock_i) begin
        if (!reset_L_i) begin
            target_reg    <= '0;
            count_reg     <= '0;
            tmo_cnt_reg   <= '0;
            overrun_reg   <= 1'b0;
            timeout_reg   <= 1'b0;
            stop_pend_reg <= 1'b0;
        end else begin
            if (accept_start) begin
                target_reg    <= num_samples_i;
                count_reg     <= '0;
                overrun_reg   <= 1'b0;
                timeout_reg   <= 1'b0;
                stop_pend_reg <= 1'b0;
            end
            if (in_issue) begin
                tmo_cnt_reg <= '0;
            end else if (in_wait) begin
                tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
            end
            if ((in_issue || in_wait) && stop_i) begin
                stop_pend_reg <= 1'b1;
            end
            if ((state_reg == SEQ_RD_WAIT) && transaction_done_i) begin
                count_reg <= count_inc;
            end
            if (((state_reg == SEQ_RD_ISSUE) || (state_reg == SEQ_RD_WAIT)) && drdy_fall) begin
                overrun_reg <= 1'b1;
            end
            if (in_wait && !transaction_done_i && tmo_expired) begin
                timeout_reg <= 1'b1;
            end
        end
    end

    assign sample_count_o = count_reg;
    assign overrun_o      = overrun_reg;
    assign timeout_o      = timeout_reg;

endmodule

// File: tb/tb_adc_acq_sequencer.sv
// Directed bench for adc_acq_sequencer with a 50-cycle done responder and a transaction monitor.
module tb_adc_acq_sequencer;
    import spi_pkg::*;

    localparam int TMO = 1000;
    localparam int LAT = 50;

    logic         clk = 1'b0;
    logic         reset_L = 1'b0;
    logic         start = 1'b0;
    logic         stop = 1'b0;
    logic [15:0]  num = 16'd0;
    logic         drdy_L = 1'b1;
    logic         done = 1'b0;
    logic         t_start;
    transaction_t t_cmd;
    logic         busy;
    logic [15:0]  count;
    logic         overrun;
    logic         timeout;

    int checks = 0;
    int errors = 0;
    int proto_err = 0;
    int cyc = 0;
    int start_cyc = 0;
    int last_done_cyc = 0;
    int idle_cyc = 0;
    bit resp_en = 1'b1;
    bit outstanding = 1'b0;
    bit prev_start = 1'b0;
    bit prev_busy = 1'b0;
    transaction_t log_q[$];

    typedef struct {
        int num;
        int period;
        int pulses;
        int width;
        int exp_count;
    } vec_t;
    vec_t vecs[4];

    adc_acq_sequencer #(.CNT_W(16), .TIMEOUT_CYC(TMO), .DO_SELFCAL(1'b1)) dut (
        .clock_i             (clk),
        .reset_L_i           (reset_L),
        .start_i             (start),
        .stop_i              (stop),
        .num_samples_i       (num),
        .DRDY_L_i            (drdy_L),
        .transaction_start_o (t_start),
        .transaction_o       (t_cmd),
        .transaction_done_i  (done),
        .busy_o              (busy),
        .sample_count_o      (count),
        .overrun_o           (overrun),
        .timeout_o           (timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Monitor: logs every issued command and checks the one-start-per-frame rule.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (t_start) begin
                if (outstanding || prev_start) proto_err++;
                outstanding = 1'b1;
                log_q.push_back(t_cmd);
                start_cyc = cyc;
                $display("txn %s issued at cycle %0d", t_cmd.name(), cyc);
            end
            if (done) begin
                outstanding = 1'b0;
                last_done_cyc = cyc;
            end
            if (!busy) outstanding = 1'b0;
            if (prev_busy && !busy) idle_cyc = cyc;
            prev_busy = busy;
            prev_start = t_start;
        end
    end

    // Responder: answers each start after LAT cycles unless reset intervenes.
    initial begin
        bit aborted;
        forever begin
            @(negedge clk);
            if (t_start && resp_en) begin
                aborted = 1'b0;
                for (int i = 0; i < LAT; i++) begin
                    @(negedge clk);
                    if (!reset_L) aborted = 1'b1;
                end
                if (!aborted) begin
                    @(posedge clk); #1 done = 1'b1;
                    @(posedge clk); #1 done = 1'b0;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk); #1;
    endtask

    task automatic do_start(input logic [15:0] n);
        @(posedge clk); #1 num = n; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic do_stop();
        @(posedge clk); #1 stop = 1'b1;
        @(posedge clk); #1 stop = 1'b0;
    endtask

    task automatic drdy_pulse(input int delay, input int width);
        repeat (delay) @(posedge clk);
        #1 drdy_L = 1'b0;
        repeat (width) @(posedge clk);
        #1 drdy_L = 1'b1;
    endtask

    task automatic wait_idle(input string name, input int budget);
        for (int i = 0; i < budget && busy; i++) tick();
        tick();
        chk(name, 32'(busy), 32'd0);
    endtask

    task automatic wait_reads(input string name, input int n, input int budget);
        for (int i = 0; i < budget && log_q.size() < n; i++) tick();
        chk(name, 32'(log_q.size() >= n), 32'd1);
    endtask

    initial begin
        int rd;
        vecs[0] = '{num: 3, period: 3333, pulses: 3, width: 20, exp_count: 3};
        vecs[1] = '{num: 2, period: 300,  pulses: 4, width: 20, exp_count: 2};
        vecs[2] = '{num: 1, period: 300,  pulses: 2, width: 20, exp_count: 1};
        vecs[3] = '{num: 4, period: 150,  pulses: 4, width: 10, exp_count: 4};

        // Reset state
        repeat (3) tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_start", 32'(t_start), 32'd0);
        chk("rst_cmd", 32'(t_cmd), 32'(RDATA));
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_flags", {30'd0, overrun, timeout}, 32'd0);
        @(posedge clk); #1 reset_L = 1'b1;
        repeat (5) tick();

        // Table-driven acquisitions with a finite target
        for (int v = 0; v < 4; v++) begin
            log_q.delete();
            do_start(16'(vecs[v].num));
            for (int p = 0; p < vecs[v].pulses; p++) drdy_pulse(vecs[v].period, vecs[v].width);
            wait_idle($sformatf("v%0d_idle", v), 2000);
            rd = 0;
            for (int i = 1; i < log_q.size(); i++) if (log_q[i] == RDATA) rd++;
            chk($sformatf("v%0d_count", v), 32'(count), 32'(vecs[v].exp_count));
            chk($sformatf("v%0d_ntxn", v), 32'(log_q.size()), 32'(vecs[v].exp_count + 1));
            chk($sformatf("v%0d_first_cal", v), 32'(log_q.size() > 0 ? log_q[0] : RDATA), 32'(SELFCAL));
            chk($sformatf("v%0d_rdata", v), 32'(rd), 32'(vecs[v].exp_count));
            chk($sformatf("v%0d_idle_after_done", v), 32'(idle_cyc - last_done_cyc), 32'd1);
            chk($sformatf("v%0d_flags", v), {30'd0, overrun, timeout}, 32'd0);
            repeat (5) tick();
        end

        // Continuous mode, stop while an RDATA is in flight
        log_q.delete();
        do_start(16'd0);
        drdy_pulse(150, 20);
        drdy_pulse(300, 20);
        drdy_pulse(300, 20);
        wait_reads("stop_reads", 4, 100);
        repeat (20) @(posedge clk);
        chk("stop_midwait_busy", 32'(busy), 32'd1);
        do_stop();
        wait_idle("stop_idle", 200);
        chk("stop_count", 32'(count), 32'd3);
        chk("stop_completed", 32'(idle_cyc - last_done_cyc), 32'd1);
        drdy_pulse(20, 20);
        repeat (100) tick();
        chk("stop_no_more", 32'(log_q.size()), 32'd4);
        chk("stop_count_held", 32'(count), 32'd3);

        // DRDY falls 10 cycles after an RDATA start
        log_q.delete();
        do_start(16'd2);
        drdy_pulse(150, 5);
        wait_reads("ovr_first", 2, 50);
        repeat (10) @(posedge clk);
        #1 drdy_L = 1'b0;
        repeat (5) @(posedge clk);
        #1 drdy_L = 1'b1;
        repeat (100) tick();
        chk("ovr_flag", 32'(overrun), 32'd1);
        chk("ovr_one_read", 32'(log_q.size()), 32'd2);
        chk("ovr_count", 32'(count), 32'd1);
        chk("ovr_armed", 32'(busy), 32'd1);
        drdy_pulse(50, 5);
        wait_idle("ovr_idle", 200);
        chk("ovr_count2", 32'(count), 32'd2);
        chk("ovr_sticky", 32'(overrun), 32'd1);

        // Hung transaction
        log_q.delete();
        resp_en = 1'b0;
        do_start(16'd1);
        wait_idle("tmo_idle", 1200);
        chk("tmo_flag", 32'(timeout), 32'd1);
        chk("tmo_cycle", 32'(idle_cyc - start_cyc), 32'(TMO + 1));
        chk("tmo_ntxn", 32'(log_q.size()), 32'd1);
        @(posedge clk); #1 done = 1'b1;
        @(posedge clk); #1 done = 1'b0;
        repeat (3) tick();
        chk("late_done_busy", 32'(busy), 32'd0);
        chk("late_done_count", 32'(count), 32'd0);
        chk("late_done_tmo", 32'(timeout), 32'd1);
        resp_en = 1'b1;

        // Reset during CAL_WAIT, start while busy, start+stop in IDLE
        log_q.delete();
        do_start(16'd3);
        wait_reads("rst_cal", 1, 10);
        repeat (10) @(posedge clk);
        do_start(16'd3);
        repeat (5) tick();
        chk("busy_start_ignored", 32'(log_q.size()), 32'd1);
        chk("busy_start_busy", 32'(busy), 32'd1);
        @(posedge clk); #1 reset_L = 1'b0;
        @(posedge clk); #1 reset_L = 1'b1;
        tick();
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_start", 32'(t_start), 32'd0);
        chk("midrst_cmd", 32'(t_cmd), 32'(RDATA));
        chk("midrst_outs", {29'd0, overrun, timeout, 1'b0} | 32'(count), 32'd0);
        @(posedge clk); #1 start = 1'b1; stop = 1'b1; num = 16'd2;
        @(posedge clk); #1 start = 1'b0; stop = 1'b0;
        tick();
        chk("startstop_busy", 32'(busy), 32'd0);
        repeat (100) tick();
        chk("startstop_ntxn", 32'(log_q.size()), 32'd1);

        // DRDY held low: edge-triggered, one read only
        log_q.delete();
        do_start(16'd5);
        repeat (100) @(posedge clk);
        #1 drdy_L = 1'b0;
        repeat (10000) @(posedge clk);
        tick();
        chk("held_ntxn", 32'(log_q.size()), 32'd2);
        chk("held_count", 32'(count), 32'd1);
        chk("held_busy", 32'(busy), 32'd1);
        #1 drdy_L = 1'b1;
        do_stop();
        @(negedge clk); #1;
        chk("arm_stop_idle", 32'(busy), 32'd0);

        chk("one_start_per_issue", 32'(proto_err), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
